// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: funct3 encodings, initiator state and
// the latched request payload.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } dmem_req_t;

  // Counter must hold values up to the timeout limit itself.
  function automatic int unsigned timeout_cnt_w(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

  localparam int unsigned TIMEOUT_CNT_W = timeout_cnt_w(TIMEOUT_DEFAULT);

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: masks and replicated store data on the way out,
// lane extraction and sign/zero extension on the way back.
module dmem_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [3:0]  mask;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata[{off, 3'b000} +: 8];
  assign rhalf = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    mask       = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        mask       = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
      end
      F3_H, F3_HU: begin
        misaligned = off[0];
        mask       = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
      end
      F3_W: begin
        misaligned = (off != 2'b00);
        mask       = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
      default: misaligned = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (we && funct3[2]) misaligned = 1'b1;
    rmask = we ? 4'b0000 : mask;
    wmask = we ? mask : 4'b0000;
    if (!we) wdata_lane = '0;
  end

endmodule

// File: rtl/dmem_initiator.sv
// Single-outstanding data-memory initiator: latches one load/store, holds it
// on the memory port until resp or timeout, and returns a one-cycle response.
module dmem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  localparam int unsigned CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

  dmem_state_t      state;
  dmem_req_t        req_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       rmask_q;
  logic [3:0]       wmask_q;

  logic        use_req;
  logic        a_we;
  logic [2:0]  a_funct3;
  logic [1:0]  a_off;
  logic [3:0]  a_rmask;
  logic [3:0]  a_wmask;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        a_misaligned;
  logic        mask_en;

  // In IDLE the aligner decodes the incoming request; otherwise the latched one.
  assign use_req  = (state == ST_IDLE);
  assign a_we     = use_req ? req_we          : req_q.we;
  assign a_funct3 = use_req ? req_funct3      : req_q.funct3;
  assign a_off    = use_req ? req_addr[1:0]   : req_q.off;

  dmem_align u_align (
    .we         (a_we),
    .funct3     (a_funct3),
    .off        (a_off),
    .wdata      (req_wdata),
    .rdata      (dmem_rdata),
    .rmask      (a_rmask),
    .wmask      (a_wmask),
    .wdata_lane (a_wdata),
    .rdata_ext  (a_rdata),
    .misaligned (a_misaligned)
  );

  // Masks drop in the resp cycle so the responder never sees a second access.
  assign mask_en    = (state == ST_BUSY) && !dmem_resp;
  assign dmem_rmask = rmask_q & {4{mask_en}};
  assign dmem_wmask = wmask_q & {4{mask_en}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      cnt        <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      req_ready  <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q.we     <= req_we;
            req_q.funct3 <= req_funct3;
            req_q.off    <= req_addr[1:0];
            req_ready    <= 1'b0;
            cnt          <= '0;
            if (a_misaligned) begin
              state <= ST_ERR;
            end else begin
              state      <= ST_BUSY;
              dmem_addr  <= {req_addr[31:2], 2'b00};
              rmask_q    <= a_rmask;
              wmask_q    <= a_wmask;
              dmem_wdata <= a_wdata;
            end
          end
        end
        ST_BUSY: begin
          if (dmem_resp) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= req_q.we ? 32'h0 : a_rdata;
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rmask_q   <= '0;
            wmask_q   <= '0;
            cnt       <= '0;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rmask_q   <= '0;
            wmask_q   <= '0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// Scoreboard bench for dmem_initiator: directed requests push expected
// responses, a negedge monitor pops and checks them; a delay-programmable responder.
module tb_dmem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic        resp_q = 1'b0;
  logic        late_resp = 1'b0;
  logic [31:0] rdata_q = 32'h0;
  bit          resp_en = 1'b1;
  int          resp_delay = 1;

  assign dmem_resp  = resp_q | late_resp;
  assign dmem_rdata = rdata_q;

  dmem_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          mask_cycles = 0;
  int          accesses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor and memory-port observer.
  bit prev_act = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      if ((|dmem_rmask) && (|dmem_wmask))
        chk("rmask_and_wmask_both_set", {dmem_rmask, dmem_wmask}, 32'h0);
      if ((|dmem_rmask) || (|dmem_wmask)) begin
        mask_cycles++;
        if (!prev_act) accesses++;
        prev_act = 1'b1;
      end else begin
        prev_act = 1'b0;
      end
    end else begin
      prev_act = 1'b0;
    end
  end

  // Responder: resp rises resp_delay cycles after masks first appear.
  int seen = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && ((|dmem_rmask) || (|dmem_wmask))) seen++;
      else seen = 0;
      if (resp_en && seen != 0 && seen >= resp_delay) begin
        @(posedge clk); #1;
        resp_q  = 1'b1;
        rdata_q = mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
        @(posedge clk); #1;
        resp_q  = 1'b0;
        rdata_q = 32'h0;
        seen    = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] ermask,
                       input logic [3:0] ewmask, input logic [31:0] ewdata,
                       input logic [31:0] erdata, input logic eerr, input int lat,
                       input bit push);
    int   n;
    exp_t e;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    if (push) begin
      e.rdata = erdata;
      e.err   = eerr;
      e.cyc   = cyc + lat;
      sb.push_back(e);
    end
    chk("req_ready_after_accept", 32'(req_ready), 32'h0);
    chk("dmem_rmask", 32'(dmem_rmask), 32'(ermask));
    chk("dmem_wmask", 32'(dmem_wmask), 32'(ewmask));
    if ((ermask | ewmask) != 4'b0000) begin
      chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("dmem_wdata", dmem_wdata, ewdata);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("response_missing", 32'(sb.size()), 32'h0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int mc0;
    int ac0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_masks", {28'h0, dmem_rmask | dmem_wmask}, 32'h0);
    chk("reset_addr", dmem_addr, 32'h0);
    chk("reset_wdata", dmem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LW aligned, resp after 6 mask cycles
    mem[32'h1000] = 32'hDEAD_BEEF;
    resp_delay = 6;
    mc0 = mask_cycles;
    ac0 = accesses;
    issue(1'b0, 3'b010, 32'h1000, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 7, 1'b1);
    wait_done();
    chk("lw_mask_cycles", 32'(mask_cycles - mc0), 32'd6);
    chk("lw_access_count", 32'(accesses - ac0), 32'd1);

    // LB / LBU at offset 3
    mem[32'h1000] = 32'h80FF_7F01;
    resp_delay = 1;
    issue(1'b0, 3'b000, 32'h1003, 32'h0, 4'b1000, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b1);
    wait_done();
    issue(1'b0, 3'b100, 32'h1003, 32'h0, 4'b1000, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 2, 1'b1);
    wait_done();
    // LH / LHU on upper half
    issue(1'b0, 3'b001, 32'h1002, 32'h0, 4'b1100, 4'b0000, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 1'b1);
    wait_done();
    issue(1'b0, 3'b101, 32'h1002, 32'h0, 4'b1100, 4'b0000, 32'h0, 32'h0000_80FF, 1'b0, 2, 1'b1);
    wait_done();

    // Stores
    mem[32'h2000] = 32'h5555_AAAA;
    issue(1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 4'b0000, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 2, 1'b1);
    wait_done();
    issue(1'b1, 3'b000, 32'h2001, 32'h0000_00C3, 4'b0000, 4'b0010, 32'hC3C3_C3C3, 32'h0, 1'b0, 2, 1'b1);
    wait_done();
    issue(1'b1, 3'b010, 32'h2000, 32'h0BAD_F00D, 4'b0000, 4'b1111, 32'h0BAD_F00D, 32'h0, 1'b0, 2, 1'b1);
    wait_done();

    // Misaligned and undefined encodings: error one cycle after acceptance
    ac0 = accesses;
    issue(1'b0, 3'b010, 32'h1001, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_done();
    issue(1'b0, 3'b001, 32'h1003, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_done();
    issue(1'b1, 3'b100, 32'h1000, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_done();
    chk("misaligned_no_access", 32'(accesses - ac0), 32'd0);

    // Timeout with resp never asserted
    resp_en = 1'b0;
    mc0 = mask_cycles;
    issue(1'b0, 3'b010, 32'h3000, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h0, 1'b1, 8, 1'b1);
    wait_done();
    chk("timeout_mask_cycles", 32'(mask_cycles - mc0), 32'd8);
    // Late resp in IDLE must be ignored
    late_resp = 1'b1;
    @(posedge clk); #1;
    late_resp = 1'b0;
    chk("late_resp_ready", 32'(req_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    resp_en = 1'b1;
    resp_delay = 2;
    mem[32'h1004] = 32'h0123_4567;
    issue(1'b0, 3'b010, 32'h1004, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h0123_4567, 1'b0, 3, 1'b1);
    wait_done();

    // Reset during BUSY aborts without a response
    resp_en = 1'b0;
    issue(1'b0, 3'b010, 32'h1008, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rmask", 32'(dmem_rmask), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    resp_en = 1'b1;
    resp_delay = 1;

    // Back-to-back loads with 1-cycle resp
    mem[32'h4000] = 32'h1111_2222;
    mem[32'h4004] = 32'h3333_4444;
    mem[32'h4008] = 32'h8000_0001;
    issue(1'b0, 3'b010, 32'h4000, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h1111_2222, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h4004, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h3333_4444, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h4008, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h8000_0001, 1'b0, 2, 1'b1);
    wait_done();

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
